led_seq_ctrl: RTL and testbench

Sequencer and arbiter that configures the LED blink divider (led_cnt div_i/wren_i) from a small programmable pattern table.
- Steps through up to NSTEPS entries, each a divider value plus a dwell time in millisecond ticks, issuing a one-cycle write strobe per step.
- A manual override requester (PS/debug) can take the divider at any time; the pattern resumes when it releases.
- Sits between top_bd_wrapper and led_cnt.

---
 rtl/led_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_led_seq_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: steps a small pattern table to program the LED blink divider.
// A manual override requester can take the divider and hand it back.
//
// Ports:
//   clk100, rstn            clock, async active-low reset
//   en_i, loop_i, last_i    run level, wrap enable, index of last entry
//   cfg_we_i/addr/div/dwell table write port (any state)
//   ovr_req_i, ovr_div_i    override request level and divider
//   ovr_ack_o               pulse when the override divider is written
//   div_o, wren_o           divider and write strobe to led_cnt
//   idx_o, busy_o, done_o   current entry, not idle, end of one-shot run
module led_seq_ctrl #(
    parameter int              DIV_W    = 5,
    parameter int              NSTEPS   = 8,
    parameter int              DWELL_W  = 16,
    parameter int              TICK_DIV = 100000,
    parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(20)
) (
    input  logic                      clk100,
    input  logic                      rstn,
    input  logic                      en_i,
    input  logic                      loop_i,
    input  logic [$clog2(NSTEPS)-1:0] last_i,
    input  logic                      cfg_we_i,
    input  logic [$clog2(NSTEPS)-1:0] cfg_addr_i,
    input  logic [DIV_W-1:0]          cfg_div_i,
    input  logic [DWELL_W-1:0]        cfg_dwell_i,
    input  logic                      ovr_req_i,
    input  logic [DIV_W-1:0]          ovr_div_i,
    output logic                      ovr_ack_o,
    output logic [DIV_W-1:0]          div_o,
    output logic                      wren_o,
    output logic [$clog2(NSTEPS)-1:0] idx_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int IW = $clog2(NSTEPS);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DWELL,
        ST_OVR
    } state_t;

    state_t             state;
    logic [IW-1:0]      idx;
    logic [PW-1:0]      presc;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DIV_W-1:0]   ovr_last;
    // done is delayed one cycle so it lands where the next strobe would be
    logic               done_pend;
    // cleared at the end of a one-shot run; en_i must drop to re-arm
    logic               armed;

    logic [DIV_W-1:0]   tbl_div   [NSTEPS];
    logic [DWELL_W-1:0] tbl_dwell [NSTEPS];

    logic               expire;
    logic               last_hit;
    logic [DWELL_W-1:0] ld_dwell;

    // final tick of the final dwell unit
    assign expire   = (presc == PS_MAX) && (dwell_cnt == DWELL_W'(1));
    // an index beyond a lowered last_i ends the pass like the last entry
    assign last_hit = (idx >= last_i);
    assign ld_dwell = (tbl_dwell[idx] == '0) ? DWELL_W'(1)
                                             : tbl_dwell[idx];

    assign busy_o = (state != ST_IDLE);
    assign idx_o  = idx;

    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            idx       <= '0;
            presc     <= '0;
            dwell_cnt <= '0;
            ovr_last  <= '0;
            done_pend <= 1'b0;
            armed     <= 1'b1;
            div_o     <= RST_DIV;
            wren_o    <= 1'b0;
            ovr_ack_o <= 1'b0;
            done_o    <= 1'b0;
            for (int i = 0; i < NSTEPS; i++) begin
                tbl_div[i]   <= RST_DIV;
                tbl_dwell[i] <= DWELL_W'(1);
            end
        end else begin
            wren_o    <= 1'b0;
            ovr_ack_o <= 1'b0;
            done_o    <= done_pend;
            done_pend <= 1'b0;

            if (!en_i)
                armed <= 1'b1;

            if (cfg_we_i) begin
                tbl_div[cfg_addr_i]   <= cfg_div_i;
                tbl_dwell[cfg_addr_i] <= cfg_dwell_i;
            end

            unique case (state)
                ST_IDLE: begin
                    if (ovr_req_i) begin
                        div_o     <= ovr_div_i;
                        wren_o    <= 1'b1;
                        ovr_ack_o <= 1'b1;
                        ovr_last  <= ovr_div_i;
                        state     <= ST_OVR;
                    end else if (en_i && armed) begin
                        idx   <= '0;
                        state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    div_o     <= tbl_div[idx];
                    wren_o    <= 1'b1;
                    dwell_cnt <= ld_dwell;
                    presc     <= '0;
                    state     <= ST_DWELL;
                end

                ST_DWELL: begin
                    if (ovr_req_i) begin
                        div_o     <= ovr_div_i;
                        wren_o    <= 1'b1;
                        ovr_ack_o <= 1'b1;
                        ovr_last  <= ovr_div_i;
                        state     <= ST_OVR;
                    end else if (!en_i) begin
                        state <= ST_IDLE;
                    end else begin
                        if (presc == PS_MAX) begin
                            presc     <= '0;
                            dwell_cnt <= dwell_cnt - 1'b1;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                        if (expire) begin
                            if (!last_hit) begin
                                idx   <= idx + 1'b1;
                                state <= ST_LOAD;
                            end else if (loop_i) begin
                                idx   <= '0;
                                state <= ST_LOAD;
                            end else begin
                                idx       <= '0;
                                done_pend <= 1'b1;
                                armed     <= 1'b0;
                                state     <= ST_IDLE;
                            end
                        end
                    end
                end

                ST_OVR: begin
                    if (!ovr_req_i) begin
                        // resume re-runs the current entry's full dwell
                        if (en_i && armed)
                            state <= ST_LOAD;
                        else
                            state <= ST_IDLE;
                    end else if (ovr_div_i != ovr_last) begin
                        div_o     <= ovr_div_i;
                        wren_o    <= 1'b1;
                        ovr_ack_o <= 1'b1;
                        ovr_last  <= ovr_div_i;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed checks of led_seq_ctrl sequencing,
// one-shot completion, override arbitration and async reset.
module tb_led_seq_ctrl;

    localparam int DIV_W   = 5;
    localparam int NSTEPS  = 8;
    localparam int DWELL_W = 8;
    localparam int IW      = $clog2(NSTEPS);

    logic               clk100;
    logic               rstn;
    logic               en_i;
    logic               loop_i;
    logic [IW-1:0]      last_i;
    logic               cfg_we_i;
    logic [IW-1:0]      cfg_addr_i;
    logic [DIV_W-1:0]   cfg_div_i;
    logic [DWELL_W-1:0] cfg_dwell_i;
    logic               ovr_req_i;
    logic [DIV_W-1:0]   ovr_div_i;
    logic               ovr_ack_o;
    logic [DIV_W-1:0]   div_o;
    logic               wren_o;
    logic [IW-1:0]      idx_o;
    logic               busy_o;
    logic               done_o;

    int n_tot = 0;
    int n_bad = 0;
    int cyc   = 0;

    led_seq_ctrl #(
        .DIV_W    (DIV_W),
        .NSTEPS   (NSTEPS),
        .DWELL_W  (DWELL_W),
        .TICK_DIV (4),
        .RST_DIV  (5'd20)
    ) dut (
        .clk100      (clk100),
        .rstn        (rstn),
        .en_i        (en_i),
        .loop_i      (loop_i),
        .last_i      (last_i),
        .cfg_we_i    (cfg_we_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_div_i   (cfg_div_i),
        .cfg_dwell_i (cfg_dwell_i),
        .ovr_req_i   (ovr_req_i),
        .ovr_div_i   (ovr_div_i),
        .ovr_ack_o   (ovr_ack_o),
        .div_o       (div_o),
        .wren_o      (wren_o),
        .idx_o       (idx_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk100);
        #1;
        cyc++;
    endtask

    // ticks until a strobe (bounded), then checks spacing, div and idx
    task automatic wait_strobe(input string tag, input int dt,
                               input int dv, input int ix);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!wren_o && n < 40);
        chk({tag, "_dt"}, n, dt);
        chk({tag, "_div"}, int'(div_o), dv);
        chk({tag, "_idx"}, int'(idx_o), ix);
    endtask

    task automatic cfg_wr(input int a, input int dv, input int dw);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = IW'(a);
        cfg_div_i   = DIV_W'(dv);
        cfg_dwell_i = DWELL_W'(dw);
        tick();
        cfg_we_i = 1'b0;
    endtask

    initial begin
        int n;
        rstn        = 1'b0;
        en_i        = 1'b0;
        loop_i      = 1'b0;
        last_i      = '0;
        cfg_we_i    = 1'b0;
        cfg_addr_i  = '0;
        cfg_div_i   = '0;
        cfg_dwell_i = '0;
        ovr_req_i   = 1'b0;
        ovr_div_i   = '0;

        #12;
        chk("rst_div",  int'(div_o),  20);
        chk("rst_wren", int'(wren_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_idx",  int'(idx_o),  0);
        chk("rst_done", int'(done_o), 0);

        @(negedge clk100);
        rstn = 1'b1;
        en_i = 1'b1;
        tick();
        chk("first_nowren", int'(wren_o), 0);
        chk("first_busy",   int'(busy_o), 1);
        tick();
        chk("first_wren", int'(wren_o), 1);
        chk("first_div",  int'(div_o),  20);

        en_i = 1'b0;
        tick();
        chk("stop_busy", int'(busy_o), 0);
        chk("stop_div",  int'(div_o),  20);

        cfg_wr(0, 3, 2);
        cfg_wr(1, 7, 0);
        cfg_wr(2, 12, 1);
        last_i = IW'(2);
        loop_i = 1'b1;
        en_i   = 1'b1;

        wait_strobe("s0", 2, 3, 0);
        wait_strobe("s1", 9, 7, 1);
        wait_strobe("s2", 5, 12, 2);
        wait_strobe("s3", 5, 3, 0);

        loop_i = 1'b0;
        wait_strobe("n1", 9, 7, 1);
        wait_strobe("n2", 5, 12, 2);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done_o && n < 40);
        chk("done_dt",   n, 5);
        chk("done_busy", int'(busy_o), 0);
        chk("done_idx",  int'(idx_o),  0);
        tick();
        chk("done_pulse", int'(done_o), 0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (wren_o) n++;
        end
        chk("norestart", n, 0);
        chk("norestart_busy", int'(busy_o), 0);

        en_i = 1'b0;
        tick();
        en_i = 1'b1;
        wait_strobe("re0", 2, 3, 0);

        loop_i = 1'b1;
        wait_strobe("o1", 9, 7, 1);
        tick();
        tick();
        ovr_req_i = 1'b1;
        ovr_div_i = 5'd31;
        tick();
        chk("ovr_wren", int'(wren_o),    1);
        chk("ovr_div",  int'(div_o),     31);
        chk("ovr_ack",  int'(ovr_ack_o), 1);
        tick();
        chk("ovr_quiet", int'(wren_o),   0);
        chk("ovr_ack0",  int'(ovr_ack_o), 0);
        ovr_div_i = 5'd2;
        tick();
        chk("ovr_upd_wren", int'(wren_o),    1);
        chk("ovr_upd_div",  int'(div_o),     2);
        chk("ovr_upd_ack",  int'(ovr_ack_o), 1);
        tick();
        chk("ovr_upd_once", int'(wren_o), 0);
        tick();
        chk("ovr_hold", int'(wren_o), 0);
        ovr_req_i = 1'b0;
        wait_strobe("rel", 2, 7, 1);
        wait_strobe("rel_dw", 5, 12, 2);

        for (int i = 0; i < 4; i++) tick();
        chk("col_load", int'(wren_o), 0);
        ovr_req_i = 1'b1;
        ovr_div_i = 5'd9;
        tick();
        chk("col_ld_wren", int'(wren_o),    1);
        chk("col_ld_div",  int'(div_o),     3);
        chk("col_ld_ack",  int'(ovr_ack_o), 0);
        tick();
        chk("col_ov_wren", int'(wren_o),    1);
        chk("col_ov_div",  int'(div_o),     9);
        chk("col_ov_ack",  int'(ovr_ack_o), 1);
        ovr_req_i = 1'b0;
        wait_strobe("col_rel", 2, 3, 0);

        wait_strobe("w1", 9, 7, 1);
        cfg_wr(1, 15, 0);
        chk("wr_live_div", int'(div_o), 7);
        wait_strobe("w2", 4, 12, 2);
        wait_strobe("w0", 5, 3, 0);
        wait_strobe("w1n", 9, 15, 1);

        tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_div",  int'(div_o),     20);
        chk("arst_wren", int'(wren_o),    0);
        chk("arst_busy", int'(busy_o),    0);
        chk("arst_idx",  int'(idx_o),     0);
        chk("arst_ack",  int'(ovr_ack_o), 0);
        @(negedge clk100);
        @(negedge clk100);
        rstn = 1'b1;
        wait_strobe("t0", 2, 20, 0);
        wait_strobe("t1", 5, 20, 1);
        wait_strobe("t2", 5, 20, 2);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
